// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: default sizes,
// operation codes, FSM state encoding and the address range check.
package dmem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH_DEF  = 32;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    WRITE  = ST_WRITE,
    READ   = ST_READ,
    VERIFY = ST_VERIFY,
    RESP   = ST_RESP
  } state_t;

  // Unsigned word-address range check against the implemented depth.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Core-side request/response handshake of the data-memory access controller.
// master = core (issues requests, accepts responses); slave = controller.
interface dmem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_store, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one load/store at a time from the
// core, sequences the memory address/read/write strobes, optionally reads a
// store back to verify it, and returns data plus error status.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter bit VERIFY_STORES = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       access_cnt
);

  state_t state;
  state_t state_nxt;
  logic   op_q;
  logic   req_fire;
  logic   req_ok;
  logic   resp_rdata_q;
  logic [DATA_W-1:0] rdata_q;

  assign req_fire = (state == IDLE) && bus.req_valid;
  assign req_ok   = addr_in_range(32'(bus.req_addr), 32'(DEPTH));
  assign resp_rdata_q = 1'b0;

  // Next-state selection and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = req_ok ? SETUP : RESP;
      end
      SETUP:  state_nxt = (op_q == OP_STORE) ? WRITE : READ;
      WRITE:  state_nxt = VERIFY_STORES ? VERIFY : RESP;
      READ:   state_nxt = RESP;
      VERIFY: state_nxt = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch: operation always, memory address/data only when in range
  // so an out-of-range request never reaches the memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_LOAD;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (req_fire) begin
      op_q <= bus.req_store;
      if (req_ok) begin
        mem_addr  <= bus.req_addr;
        mem_wdata <= bus.req_wdata;
      end
    end
  end

  // Write strobe is low exactly while the FSM sits in WRITE; reset lifts it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_read <= 1'b1;
    else     mem_read <= (state_nxt != WRITE);
  end

  // Response data/error capture; held unchanged through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q      <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire && !req_ok) begin
            rdata_q      <= '0;
            bus.resp_err <= 1'b1;
          end
        end
        WRITE: begin
          if (!VERIFY_STORES) begin
            rdata_q      <= '0;
            bus.resp_err <= 1'b0;
          end
        end
        READ: begin
          rdata_q      <= mem_rdata;
          bus.resp_err <= 1'b0;
        end
        VERIFY: begin
          rdata_q      <= mem_rdata;
          bus.resp_err <= (mem_rdata != mem_wdata) | resp_rdata_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;

  // Completed-access counter, stepped on each response handoff (wraps).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                access_cnt <= '0;
    else if (state == RESP && bus.resp_ready) access_cnt <= access_cnt + 16'd1;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases then randomized load/store
// traffic against a transaction-level shadow of the 32-word memory.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  mem_addr;
  logic        mem_read;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] access_cnt;
  logic        corrupt;

  logic [15:0] mem     [0:63];
  logic [15:0] ref_mem [0:63];
  logic [15:0] exp_cnt;

  int vectors;
  int miscompares;

  dmem_access_ctrl_if #(.DATA_W(16), .ADDR_W(6)) ifc ();

  dmem_access_ctrl #(
    .DATA_W(16), .ADDR_W(6), .DEPTH(32), .VERIFY_STORES(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .access_cnt (access_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: preset word i = i while reset is held, write on mem_read low.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i);
    end else if (!mem_read) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr] ^ {15'd0, corrupt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_preset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'(i);
  endtask

  // One full transaction: issue, measure latency and write strobes, check the
  // response, hold it for 'hold' cycles under fresh ignored requests, hand off.
  task automatic do_txn(input logic st, input logic [5:0] addr, input logic [15:0] wd,
                        input int hold);
    logic        inr;
    int          exp_lat, exp_low, cyc, lows;
    logic [15:0] exp_rd;
    logic        exp_err;
    inr     = (addr < 6'd32);
    exp_lat = !inr ? 1 : (st ? 4 : 3);
    exp_low = (inr && st) ? 1 : 0;
    exp_rd  = !inr ? 16'h0 : (st ? (wd ^ {15'd0, corrupt}) : ref_mem[addr]);
    exp_err = !inr || (st && corrupt);

    @(negedge clk);
    check("req_ready_idle", 32'(ifc.req_ready), 32'd1);
    ifc.req_valid = 1'b1;
    ifc.req_store = st;
    ifc.req_addr  = addr;
    ifc.req_wdata = wd;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_store = 1'($urandom);
    ifc.req_addr  = 6'($urandom);
    ifc.req_wdata = 16'($urandom);

    cyc  = 0;
    lows = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_read === 1'b0) lows++;
    end while (ifc.resp_valid !== 1'b1 && cyc < 20);

    check("latency", 32'(cyc), 32'(exp_lat));
    check("write_cycles", 32'(lows), 32'(exp_low));
    check("resp_rdata", 32'(ifc.resp_rdata), 32'(exp_rd));
    check("resp_err", 32'(ifc.resp_err), 32'(exp_err));
    if (inr && st) ref_mem[addr] = wd;

    for (int i = 0; i < hold; i++) begin
      ifc.req_valid = 1'b1;
      ifc.req_addr  = 6'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(ifc.resp_valid), 32'd1);
      check("hold_rdata", 32'(ifc.resp_rdata), 32'(exp_rd));
      check("hold_req_ready", 32'(ifc.req_ready), 32'd0);
      check("hold_mem_read", 32'(mem_read), 32'd1);
    end
    ifc.req_valid  = 1'b0;
    ifc.resp_ready = 1'b1;
    @(posedge clk);
    exp_cnt = exp_cnt + 16'd1;
    #1;
    ifc.resp_ready = 1'b0;
    @(negedge clk);
    check("resp_drop", 32'(ifc.resp_valid), 32'd0);
    check("back_idle", 32'(ifc.req_ready), 32'd1);
    check("access_cnt", 32'(access_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int w;
    vectors        = 0;
    miscompares    = 0;
    corrupt        = 1'b0;
    exp_cnt        = 16'd0;
    rst            = 1'b1;
    ifc.req_valid  = 1'b0;
    ifc.req_store  = 1'b0;
    ifc.req_addr   = 6'd0;
    ifc.req_wdata  = 16'd0;
    ifc.resp_ready = 1'b0;
    ref_preset();

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_mem_read", 32'(mem_read), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(ifc.resp_rdata), 32'd0);
    check("rst_resp_err", 32'(ifc.resp_err), 32'd0);
    check("rst_access_cnt", 32'(access_cnt), 32'd0);
    rst = 1'b0;

    // Directed cases.
    do_txn(1'b0, 6'd5, 16'h0000, 0);
    do_txn(1'b1, 6'd31, 16'hBEEF, 0);
    do_txn(1'b0, 6'd31, 16'h0000, 0);
    do_txn(1'b0, 6'd40, 16'h0000, 0);
    do_txn(1'b1, 6'd32, 16'h5555, 1);
    corrupt = 1'b1;
    do_txn(1'b1, 6'd7, 16'h1234, 0);
    corrupt = 1'b0;
    do_txn(1'b0, 6'd7, 16'h0000, 0);
    do_txn(1'b0, 6'd3, 16'h0000, 5);

    // Reset while the write strobe is active.
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_store = 1'b1;
    ifc.req_addr  = 6'd9;
    ifc.req_wdata = 16'hA5A5;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (mem_read !== 1'b0 && w < 10);
    check("write_reached", 32'(mem_read), 32'd0);
    rst = 1'b1;
    #1;
    check("rstw_mem_read", 32'(mem_read), 32'd1);
    check("rstw_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rstw_access_cnt", 32'(access_cnt), 32'd0);
    check("rstw_req_ready", 32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    ref_preset();
    do_txn(1'b0, 6'd9, 16'h0000, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 6'($urandom_range(0, 47)), 16'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
